// File: rtl/pcm_dac_pkg.sv
// Shared types and constants for the PCM-to-PWM audio DAC.
// Holds the sample width, midscale value, FSM encoding and dither LFSR settings.
package pcm_dac_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [15:0] MIDSCALE = 16'h0000;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois taps 16,14,13,11 for a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    PRIME = 1'b0,
    PLAY  = 1'b1
  } dac_state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with registered read data.
// Occupancy is a separate counter; pointers wrap modulo depth.
module sample_fifo
  import pcm_dac_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [SAMPLE_W-1:0] wr_data,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic [AW:0]         level
);

  logic [SAMPLE_W-1:0] mem [2**AW];
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;

  // Storage write port, no reset needed on the array.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_data;
  end

  // Pointers, registered read data and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= MIDSCALE;
      level   <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr    <= rptr + 1'b1;
        rd_data <= mem[rptr];
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pcm_pwm_dac.sv
// PCM sample buffer, fixed-rate playback FSM and PWM audio output.
// Optional dither: define PCM_DAC_DITHER_EN to add LFSR noise before truncation.
module pcm_pwm_dac
  import pcm_dac_pkg::*;
#(
  parameter int CLK_HZ    = 27000000,
  parameter int SAMPLE_HZ = 44100,
  parameter int FIFO_AW   = 4,
  parameter int PWM_BITS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  input  logic                flags_clr,
  output logic                pwm_out,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                underrun,
  output logic                overflow,
  output logic                playing
);

  localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] HALF_L = (FIFO_AW+1)'(DEPTH/2);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SAMPLE_DIV-1);
  localparam logic [PWM_BITS-1:0] MID_DUTY =
    PWM_BITS'((MIDSCALE ^ 16'h8000) >> (16-PWM_BITS));

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  dac_state_e          state;
  logic                mid_q;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                drop;
  logic                starve;
  logic [SAMPLE_W-1:0] rd_data;
  logic [SAMPLE_W-1:0] cur_sample;
  logic [15:0]         u;
  logic [15:0]         ud;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] pwm_cnt;

  assign tick       = (div_cnt == DIV_MAX);
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == DEPTH_L);
  assign pop        = tick && (state == PLAY) && !fifo_empty;
  assign starve     = tick && (state == PLAY) && fifo_empty;
  assign push       = sample_valid && (!fifo_full || pop);
  assign drop       = sample_valid && !push;

  sample_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .wr_data(sample_data),
    .rd_data(rd_data),
    .level  (fifo_level)
  );

  // Sample-rate divider, free-running in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  // Playback FSM: prime until half full, then pop one sample per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PRIME;
      playing <= 1'b0;
      mid_q   <= 1'b1;
    end else if (tick) begin
      unique case (state)
        PRIME: begin
          mid_q <= 1'b1;
          if (fifo_level >= HALF_L) begin
            state   <= PLAY;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          if (fifo_empty) begin
            state   <= PRIME;
            playing <= 1'b0;
            mid_q   <= 1'b1;
          end else begin
            mid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Sticky flags; a set event wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (starve) underrun <= 1'b1;
      else if (flags_clr) underrun <= 1'b0;
      if (drop) overflow <= 1'b1;
      else if (flags_clr) overflow <= 1'b0;
    end
  end

  assign cur_sample = mid_q ? MIDSCALE : rd_data;
  assign u = cur_sample ^ 16'h8000;

`ifdef PCM_DAC_DITHER_EN
  logic [15:0] lfsr;
  logic [16:0] dsum;

  // Dither source steps once per sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else if (tick) lfsr <= lfsr_next(lfsr);
  end

  // Add low LFSR bits, saturating at full scale.
  always_comb begin
    dsum = {1'b0, u} + 17'(lfsr[15-PWM_BITS:0]);
    ud = dsum[16] ? 16'hFFFF : dsum[15:0];
  end
`else
  // Plain truncation path.
  always_comb begin
    ud = u;
  end
`endif

  assign duty = PWM_BITS'(ud >> (16-PWM_BITS));

  // PWM carrier; duty reloads only at period end to avoid glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty_q  <= MID_DUTY;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (&pwm_cnt) duty_q <= duty;
      pwm_out <= (pwm_cnt < duty_q);
    end
  end

endmodule

// File: tb/tb_pcm_pwm_dac.sv
// Self-checking bench for pcm_pwm_dac (default build, dither off).
// Cycle model of divider, FIFO level, FSM and flags plus a duty scoreboard.
module tb_pcm_pwm_dac;

  localparam int DIV = 27000000 / 44100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        flags_clr = 1'b0;
  logic        pwm_out;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic        overflow;
  logic        playing;

  always #5 clk = ~clk;

  pcm_pwm_dac dut (
    .clk         (clk),
    .rst         (rst),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .flags_clr   (flags_clr),
    .pwm_out     (pwm_out),
    .fifo_level  (fifo_level),
    .underrun    (underrun),
    .overflow    (overflow),
    .playing     (playing)
  );

  typedef struct {
    logic [15:0] s;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl [8];

  int nchk = 0;
  int nfail = 0;
  int m_div = 0;
  int m_level = 0;
  bit m_play = 0;
  logic [7:0] m_cur = 8'h80;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] duty_of(input logic [15:0] s);
    logic [15:0] u;
    u = s ^ 16'h8000;
    return u[15:8];
  endfunction

  // One clock with the bench model advanced in lockstep.
  task automatic step(input logic v, input logic [15:0] d, input logic clr);
    bit tk, pp, un, acc;
    sample_valid = v;
    sample_data  = d;
    flags_clr    = clr;
    tk  = (m_div == DIV-1);
    pp  = tk && m_play && (m_level != 0);
    un  = tk && m_play && (m_level == 0);
    acc = v && ((m_level < 16) || pp);
    if (acc) exp_q.push_back(duty_of(d));
    if (pp) begin
      if (exp_q.size() > 0) m_cur = exp_q.pop_front();
    end
    if (un) m_cur = 8'h80;
    if (tk) begin
      if (!m_play && m_level >= 8) m_play = 1;
      else if (un) m_play = 0;
    end
    m_level = m_level + (acc ? 1 : 0) - (pp ? 1 : 0);
    m_div = tk ? 0 : m_div + 1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    flags_clr    = 1'b0;
  endtask

  task automatic to_tick();
    int g;
    g = 0;
    while (m_div != DIV-1 && g < 2*DIV) begin
      step(1'b0, 16'h0, 1'b0);
      g++;
    end
  endtask

  // Count high cycles over one full PWM period once the new duty is live.
  task automatic measure(output int hi);
    repeat (258) step(1'b0, 16'h0, 1'b0);
    hi = 0;
    repeat (256) begin
      step(1'b0, 16'h0, 1'b0);
      hi += int'(pwm_out);
    end
  endtask

  task automatic model_reset();
    m_div = 0;
    m_level = 0;
    m_play = 0;
    m_cur = 8'h80;
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_playing"}, playing, 0);
    chk({tag, "_pwm"}, pwm_out, 0);
  endtask

  initial begin
    int hi;
    tbl[0] = '{16'h7FFF, 8'hFF};
    tbl[1] = '{16'h8000, 8'h00};
    tbl[2] = '{16'h0000, 8'h80};
    tbl[3] = '{16'h1234, 8'h92};
    tbl[4] = '{16'hFFFF, 8'h7F};
    tbl[5] = '{16'hC000, 8'h40};
    tbl[6] = '{16'h4000, 8'hC0};
    tbl[7] = '{16'h8001, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst0");
    rst = 1'b0;
    model_reset();

    measure(hi);
    chk("prime_mid_duty", hi, 128);

    for (int i = 0; i < 8; i++) step(1'b1, tbl[i].s, 1'b0);
    chk("fill8_level", fifo_level, 8);
    to_tick();
    step(1'b0, 16'h0, 1'b0);
    chk("start_playing", playing, 1);
    chk("start_level", fifo_level, 8);

    for (int i = 0; i < 8; i++) begin
      to_tick();
      step(1'b0, 16'h0, 1'b0);
      chk("pop_level", fifo_level, 7 - i);
      measure(hi);
      chk("tbl_duty", hi, tbl[i].d);
      chk("sb_duty", hi, m_cur);
    end

    to_tick();
    step(1'b0, 16'h0, 1'b0);
    chk("underrun_set", underrun, 1);
    chk("underrun_playing", playing, 0);
    measure(hi);
    chk("underrun_mid_duty", hi, 128);
    step(1'b0, 16'h0, 1'b1);
    chk("underrun_clr", underrun, 0);

    for (int i = 0; i < 8; i++) step(1'b1, tbl[7-i].s, 1'b0);
    to_tick();
    step(1'b0, 16'h0, 1'b0);
    chk("resume_playing", playing, 1);
    for (int i = 0; i < 3; i++) begin
      to_tick();
      step(1'b0, 16'h0, 1'b0);
      measure(hi);
      chk("resume_duty", hi, m_cur);
    end
    chk("pre_rst_level", fifo_level, m_level);
    chk("pre_rst_level5", fifo_level, 5);
    chk("pre_rst_playing", playing, 1);

    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_pwm", pwm_out, 0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 16; i++) step(1'b1, 16'(i * 16'h1111), 1'b0);
    step(1'b1, 16'h7FFF, 1'b0);
    chk("full_level", fifo_level, 16);
    chk("full_overflow", overflow, 1);
    step(1'b0, 16'h0, 1'b1);
    chk("ovf_clr", overflow, 0);
    step(1'b1, 16'h7FFF, 1'b1);
    chk("ovf_set_wins", overflow, 1);
    step(1'b0, 16'h0, 1'b1);
    chk("ovf_clr2", overflow, 0);

    to_tick();
    step(1'b0, 16'h0, 1'b0);
    chk("full_play", playing, 1);
    chk("full_no_pop", fifo_level, 16);
    to_tick();
    step(1'b1, 16'h8000, 1'b0);
    chk("pushpop_level", fifo_level, 16);
    chk("pushpop_overflow", overflow, 0);
    measure(hi);
    chk("drain_duty", hi, m_cur);
    for (int i = 0; i < 16; i++) begin
      to_tick();
      step(1'b0, 16'h0, 1'b0);
      measure(hi);
      chk("drain_duty", hi, m_cur);
    end
    chk("last_is_pushpop", hi, 0);
    to_tick();
    step(1'b0, 16'h0, 1'b0);
    chk("final_underrun", underrun, 1);
    chk("final_level", fifo_level, 0);
    chk("final_playing", playing, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
